// File: rtl/serial_tx_if.sv
// Word handshake into the serializer: source drives in_data/in_valid, serializer returns in_ready.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_tx.sv
// Serializer: start bit, DATA_W bits LSB first, stop bit, each held CLKS_PER_BIT clks; first start cycle follows accept edge.
// Backpressure: in_ready only in IDLE, so a held word waits through the frame and is taken in the first idle cycle.
module serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  serial_tx_if.slave  s_if,
  output logic        tx,
  output logic        busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shreg_nxt;
  logic              tx_d;
  logic              bit_done;

  assign bit_done    = (cnt_q == CNT_LAST);
  assign shreg_nxt   = shreg_q >> 1;
  assign s_if.in_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx      <= tx_d;
    end
  end

  // tx_d is the level of the bit that starts in the cycle after this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx;
    if (state_q != IDLE) begin
      cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (s_if.in_valid) begin
          shreg_d = s_if.in_data;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_nxt;
            tx_d    = shreg_nxt[0];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench: two serializers (4 and 1 clks per bit) checked cycle by cycle against a frame-position model.
module tb_serial_tx;

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  logic tx0, busy0, tx1, busy1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_tx_if #(.DATA_W(8)) if0 ();
  serial_tx_if #(.DATA_W(8)) if1 ();

  serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut0 (
    .clk(clk), .reset_n(rst0_n), .s_if(if0), .tx(tx0), .busy(busy0));
  serial_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
    .clk(clk), .reset_n(rst1_n), .s_if(if1), .tx(tx1), .busy(busy1));

  // Expected line level at 0-based cycle cyc of a frame: position k = cyc / cpb.
  function automatic logic exp_bit(input logic [7:0] d, input int cyc, input int cpb);
    int k;
    k = cyc / cpb;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic v, input logic [7:0] d);
    if (u == 0) begin
      if0.in_valid = v;
      if0.in_data  = d;
    end else begin
      if1.in_valid = v;
      if1.in_data  = d;
    end
  endtask

  task automatic sample(input int u, output logic t, output logic b, output logic r);
    if (u == 0) begin
      t = tx0; b = busy0; r = if0.in_ready;
    end else begin
      t = tx1; b = busy1; r = if1.in_ready;
    end
  endtask

  // Caller arrives in an IDLE cycle. keep=1 holds in_valid with nd through the frame.
  task automatic frame(input int u, input logic [7:0] d, input bit keep, input logic [7:0] nd);
    int   cpb;
    int   len;
    logic t, b, r;
    cpb = (u == 0) ? 4 : 1;
    len = 10 * cpb;
    drive(u, 1'b1, d);
    tick;
    if (keep) drive(u, 1'b1, nd);
    for (int i = 0; i < len; i++) begin
      sample(u, t, b, r);
      check($sformatf("u%0d d=%02h cyc%0d tx", u, d, i + 1), 16'(t), 16'(exp_bit(d, i, cpb)));
      check($sformatf("u%0d d=%02h cyc%0d busy", u, d, i + 1), 16'(b), 16'd1);
      check($sformatf("u%0d d=%02h cyc%0d in_ready", u, d, i + 1), 16'(r), 16'd0);
      if (!keep) drive(u, (i < len - 1) ? 1'($urandom) : 1'b0, 8'($urandom));
      tick;
    end
    sample(u, t, b, r);
    check($sformatf("u%0d d=%02h end in_ready", u, d), 16'(r), 16'd1);
    check($sformatf("u%0d d=%02h end tx", u, d), 16'(t), 16'd1);
    check($sformatf("u%0d d=%02h end busy", u, d), 16'(b), 16'd0);
  endtask

  task automatic idle_cycles(input int u, input int n);
    logic t, b, r;
    drive(u, 1'b0, 8'($urandom));
    for (int i = 0; i < n; i++) begin
      sample(u, t, b, r);
      check($sformatf("u%0d idle tx", u), 16'(t), 16'd1);
      check($sformatf("u%0d idle in_ready", u), 16'(r), 16'd1);
      tick;
    end
  endtask

  // Assert reset at cycle `at` of a frame of d, verify instant tx=1 and a clean line afterwards.
  task automatic reset_mid(input logic [7:0] d, input int at);
    drive(0, 1'b1, d);
    tick;
    drive(0, 1'b0, 8'h00);
    for (int i = 0; i < at - 1; i++) begin
      check("rst pre tx", 16'(tx0), 16'(exp_bit(d, i, 4)));
      tick;
    end
    check("rst pre busy", 16'(busy0), 16'd1);
    #2 rst0_n = 1'b0;
    #1;
    check("rst async tx", 16'(tx0), 16'd1);
    check("rst async busy", 16'(busy0), 16'd0);
    check("rst async in_ready", 16'(if0.in_ready), 16'd1);
    tick;
    check("rst held tx", 16'(tx0), 16'd1);
    rst0_n = 1'b1;
    for (int i = 0; i < 45; i++) begin
      check("post rst tx", 16'(tx0), 16'd1);
      check("post rst busy", 16'(busy0), 16'd0);
      tick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    #1;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    #2;
    check("reset tx0", 16'(tx0), 16'd1);
    check("reset busy0", 16'(busy0), 16'd0);
    check("reset in_ready0", 16'(if0.in_ready), 16'd1);
    check("reset tx1", 16'(tx1), 16'd1);
    check("reset busy1", 16'(busy1), 16'd0);
    drive(0, 1'b1, 8'hA5);
    tick;
    tick;
    check("reset held tx0", 16'(tx0), 16'd1);
    check("reset held busy0", 16'(busy0), 16'd0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    // First edge after reset release with in_valid high is an accept.
    frame(0, 8'hA5, 1'b0, 8'h00);
    idle_cycles(0, 2);

    // Held valid: 0x00 then 0xFF separated by exactly one idle cycle.
    frame(0, 8'h00, 1'b1, 8'hFF);
    frame(0, 8'hFF, 1'b0, 8'h00);
    idle_cycles(0, 1);

    // Data change while busy: frame keeps 0x3C, the held 0xC3 follows once.
    frame(0, 8'h3C, 1'b1, 8'hC3);
    frame(0, 8'hC3, 1'b0, 8'h00);
    idle_cycles(0, 3);

    for (int n = 0; n < 6; n++) begin
      idle_cycles(0, int'($urandom_range(0, 3)));
      frame(0, 8'($urandom), 1'b0, 8'h00);
    end

    reset_mid(8'h0F, 13);
    reset_mid(8'h00, 2);
    frame(0, 8'h5A, 1'b0, 8'h00);

    // One clock per bit.
    idle_cycles(1, 1);
    frame(1, 8'h81, 1'b0, 8'h00);
    frame(1, 8'h7E, 1'b0, 8'h00);
    for (int n = 0; n < 4; n++) begin
      idle_cycles(1, int'($urandom_range(0, 2)));
      frame(1, 8'($urandom), 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, is the number of clk cycles each serial bit is held; legal range is 1 to 65535.
REQ-002 Parameter DATA_W, default 8, is the number of payload bits per frame; legal range is 1 to 16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk.
REQ-005 in_data  input  DATA_W  parallel word to be serialized.
REQ-006 in_valid  input  1  source presents in_data.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 tx  output  1  serial line; idle level is 1.
REQ-009 busy  output  1  a frame is in progress.

Function
REQ-010 The block SHALL use the states IDLE, START, DATA and STOP.
REQ-011 in_ready SHALL be 1 exactly when the state is IDLE; it SHALL be decoded combinationally from state.
REQ-012 busy SHALL be 1 exactly when the state is not IDLE.
REQ-013 Accept occurs on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be latched into a shift register at that edge, and the state SHALL move to START.
REQ-014 in_valid=0 in IDLE SHALL leave the state in IDLE with tx=1.
REQ-015 tx SHALL be a registered output; it changes only on clk edges or on reset assertion.
REQ-016 The frame is sent in this order:
 - one start bit of 0;
 - DATA_W data bits, LSB first;
 - one stop bit of 1.
REQ-017 Each bit SHALL drive tx for exactly CLKS_PER_BIT consecutive cycles. The first start-bit cycle is the cycle right after the accept edge.
REQ-018 A bit-period counter SHALL count 0..CLKS_PER_BIT-1. On the terminal count it SHALL wrap to 0 and the block SHALL advance to the next bit or state.
REQ-019 A bit index SHALL count 0..DATA_W-1 in DATA. When the index is DATA_W-1 at terminal count, the state SHALL move to STOP.
REQ-020 After the stop bit completes, the state SHALL move to IDLE. The frame therefore occupies (DATA_W+2)*CLKS_PER_BIT cycles.
REQ-021 Back-to-back words: in_ready is 1 in the first IDLE cycle, so at least one idle cycle (tx=1) separates consecutive frames.
REQ-022 Changes on in_data or in_valid while busy=1 SHALL NOT affect the frame in progress.
REQ-023 A word held on in_valid during busy SHALL be accepted in the first IDLE cycle and SHALL NOT be lost or duplicated.
REQ-024 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle and the counter SHALL stay at 0.
REQ-025 Counter widths SHALL be large enough that no count overflows anywhere in the legal parameter ranges.

Reset
REQ-026 While reset_n=0 the block SHALL hold:
 - state=IDLE, tx=1, busy=0, in_ready=1;
 - bit-period counter=0, bit index=0;
 - shift register=0.
REQ-027 Asserting reset_n mid-frame SHALL force tx=1 immediately without waiting for clk and SHALL discard the partial frame.
REQ-028 After reset_n rises, the first clk edge with in_valid=1 SHALL be a valid accept.

Verification
REQ-029 CLKS_PER_BIT=4, DATA_W=8, send 0xA5 -> tx over 40 cycles after accept is:
 - 0 for 4 cycles;
 - then 1,0,1,0,0,1,0,1, each held 4 cycles;
 - then 1 for 4 cycles;
 - then in_ready=1 on cycle 41.
REQ-030 in_valid held high with 0x00 then 0xFF -> two frames:
 - 0x00 frame: 36 cycles low, then 4 cycles high;
 - exactly one idle cycle between the frames;
 - 0xFF frame: 4 cycles low, then 36 cycles high.
REQ-031 Drive reset_n low asynchronously at cycle 13 of a frame of 0x0F -> tx=1 before the next clk edge, busy=0, and no residual bits after reset_n releases.
REQ-032 Change in_data from 0x3C to 0xC3 during busy -> the serialized bits match 0x3C only, and there is no second accept until IDLE.
REQ-033 CLKS_PER_BIT=1, send 0x81 -> tx sequence 0,1,0,0,0,0,0,0,1,1 over 10 cycles, then in_ready=1.
